// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with branch resolve, forwarding and load-use detect
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        wb_ctl_in,
  input  logic [2:0]        m_ctl_in,
  input  logic [DATA_W-1:0] br_target_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  dest_reg_in,
  input  logic [REG_W-1:0]  ex_rs,
  input  logic [REG_W-1:0]  ex_rt,
  output logic              out_valid,
  output logic [1:0]        wb_ctl_out,
  output logic [2:0]        m_ctl_out,
  output logic [DATA_W-1:0] br_target_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [REG_W-1:0]  dest_reg_out,
  output logic              pcsrc,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              load_use
);

  logic dest_nz;

  // Reset and flush both leave a bubble; flush outranks stall.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid      <= 1'b0;
      wb_ctl_out     <= '0;
      m_ctl_out      <= '0;
      br_target_out  <= '0;
      zero_out       <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      dest_reg_out   <= '0;
    end else if (!stall) begin
      out_valid      <= in_valid;
      wb_ctl_out     <= in_valid ? wb_ctl_in : 2'b00;
      m_ctl_out      <= in_valid ? m_ctl_in : 3'b000;
      br_target_out  <= br_target_in;
      zero_out       <= zero_in;
      alu_result_out <= alu_result_in;
      store_data_out <= store_data_in;
      dest_reg_out   <= dest_reg_in;
    end
  end

  // Register 0 is hardwired zero, so it never produces a hazard.
  assign dest_nz  = (dest_reg_out != '0);
  assign pcsrc    = out_valid & m_ctl_out[2] & zero_out;
  assign fwd_a    = out_valid & wb_ctl_out[1] & dest_nz & (dest_reg_out == ex_rs);
  assign fwd_b    = out_valid & wb_ctl_out[1] & dest_nz & (dest_reg_out == ex_rt);
  assign load_use = out_valid & m_ctl_out[1] & dest_nz &
                    ((dest_reg_out == ex_rs) | (dest_reg_out == ex_rt));

endmodule
